// File: rtl/datapath.sv
// datapath: single-bus register file (PC/IR/MAR/MDR/RY/R0/R1)
// with a combinational ALU whose result is captured in RZ.
//
// Ports:
//   clock          rising-edge clock
//   clear          async active-low reset of every register
//   pci..r1o       per-register in-strobes (*i) and out-strobes (*o)
//   *_immediate    external load values for PC, IR, MAR, MDR
//   pc, ir         reserved, ignored
//   bus            current bus value (combinational)
//   rz             registered ALU result
module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        pci,
  input  logic        pco,
  input  logic        iri,
  input  logic        iro,
  input  logic        mari,
  input  logic        maro,
  input  logic        mdri,
  input  logic        mdro,
  input  logic        ryi,
  input  logic        ryo,
  input  logic        r0i,
  input  logic        r0o,
  input  logic        r1i,
  input  logic        r1o,
  input  logic [31:0] pc_immediate,
  input  logic [31:0] ir_immediate,
  input  logic [31:0] mar_immediate,
  input  logic [31:0] mdr_immediate,
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  output logic [31:0] bus,
  output logic [31:0] rz
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHRA = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_NOT  = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b01011;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mar;
  logic [31:0] r_mdr;
  logic [31:0] r_ry;
  logic [31:0] r_r0;
  logic [31:0] r_r1;
  logic [31:0] r_rz;

  logic [31:0] w_bus;
  logic [31:0] w_alu;
  logic        w_any_out;
  logic        w_rz_ld;
  logic [4:0]  w_op;
  logic [4:0]  w_sh;
  logic [5:0]  w_shc;
  logic [31:0] w_pc_d;
  logic [31:0] w_ir_d;
  logic [31:0] w_mar_d;
  logic [31:0] w_mdr_d;
  logic signed [31:0] w_ry_s;
  logic        w_unused;

  // pc/ir are reserved inputs with no function.
  assign w_unused = ^{pc, ir};

  assign w_any_out = pco | iro | maro | mdro |
                     ryo | r0o | r1o;

  always_comb begin
    w_bus = '0;
    priority case (1'b1)
      pco:     w_bus = r_pc;
      iro:     w_bus = r_ir;
      maro:    w_bus = r_mar;
      mdro:    w_bus = r_mdr;
      ryo:     w_bus = r_ry;
      r0o:     w_bus = r_r0;
      r1o:     w_bus = r_r1;
      default: w_bus = '0;
    endcase
  end

  assign bus = w_bus;
  assign rz  = r_rz;

  // Memory-facing registers fall back to their
  // immediate when nothing drives the bus.
  assign w_pc_d  = w_any_out ? w_bus : pc_immediate;
  assign w_ir_d  = w_any_out ? w_bus : ir_immediate;
  assign w_mar_d = w_any_out ? w_bus : mar_immediate;
  assign w_mdr_d = w_any_out ? w_bus : mdr_immediate;

  assign w_op   = r_ir[31:27];
  assign w_sh   = w_bus[4:0];
  // Complementary rotate amount; 32 shifts out to 0,
  // so a zero amount leaves A unchanged.
  assign w_shc  = 6'd32 - {1'b0, w_sh};
  assign w_ry_s = r_ry;

  always_comb begin
    w_alu = w_bus;
    unique case (w_op)
      OP_ADD:  w_alu = r_ry + w_bus;
      OP_SUB:  w_alu = r_ry - w_bus;
      OP_AND:  w_alu = r_ry & w_bus;
      OP_OR:   w_alu = r_ry | w_bus;
      OP_SHR:  w_alu = r_ry >> w_sh;
      OP_SHRA: w_alu = w_ry_s >>> w_sh;
      OP_SHL:  w_alu = r_ry << w_sh;
      OP_ROR:  w_alu = (r_ry >> w_sh) |
                       (r_ry << w_shc);
      OP_ROL:  w_alu = (r_ry << w_sh) |
                       (r_ry >> w_shc);
      OP_NOT:  w_alu = ~w_bus;
      OP_NEG:  w_alu = 32'd0 - w_bus;
      default: w_alu = w_bus;
    endcase
  end

  // RY load marks operand setup, not an operation.
  assign w_rz_ld = (r0o | r1o) & ~ryi;

  // A register both driving and loading keeps its value.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_ry  <= '0;
      r_r0  <= '0;
      r_r1  <= '0;
      r_rz  <= '0;
    end else begin
      if (pci  && !pco)  r_pc  <= w_pc_d;
      if (iri  && !iro)  r_ir  <= w_ir_d;
      if (mari && !maro) r_mar <= w_mar_d;
      if (mdri && !mdro) r_mdr <= w_mdr_d;
      if (ryi  && !ryo)  r_ry  <= w_bus;
      if (r0i  && !r0o)  r_r0  <= w_bus;
      if (r1i  && !r1o)  r_r1  <= w_bus;
      if (w_rz_ld)       r_rz  <= w_alu;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: randomized + directed scoreboard bench
// for the single-bus datapath.
module tb_datapath;

  localparam logic [6:0] B_PC  = 7'd1;
  localparam logic [6:0] B_IR  = 7'd2;
  localparam logic [6:0] B_MAR = 7'd4;
  localparam logic [6:0] B_MDR = 7'd8;
  localparam logic [6:0] B_RY  = 7'd16;
  localparam logic [6:0] B_R0  = 7'd32;
  localparam logic [6:0] B_R1  = 7'd64;

  typedef struct {
    string       nm;
    logic [31:0] bus;
    logic [31:0] rz;
    bit          cb;
    logic [31:0] vb;
    bit          cr;
    logic [31:0] vr;
  } exp_t;

  logic        clock;
  logic        clear;
  logic [6:0]  in_s;
  logic [6:0]  out_s;
  logic [31:0] imm [7];
  logic [31:0] pc_junk;
  logic [31:0] ir_junk;
  logic [31:0] bus;
  logic [31:0] rz;

  // reference state, index order = bus priority order
  logic [31:0] m [7];
  logic [31:0] m_rz;

  exp_t q [$];
  exp_t e;
  int checks;
  int errors;

  datapath dut (
    .clock(clock), .clear(clear),
    .pci(in_s[0]),  .pco(out_s[0]),
    .iri(in_s[1]),  .iro(out_s[1]),
    .mari(in_s[2]), .maro(out_s[2]),
    .mdri(in_s[3]), .mdro(out_s[3]),
    .ryi(in_s[4]),  .ryo(out_s[4]),
    .r0i(in_s[5]),  .r0o(out_s[5]),
    .r1i(in_s[6]),  .r1o(out_s[6]),
    .pc_immediate(imm[0]),
    .ir_immediate(imm[1]),
    .mar_immediate(imm[2]),
    .mdr_immediate(imm[3]),
    .pc(pc_junk), .ir(ir_junk),
    .bus(bus), .rz(rz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [31:0] alu_model(
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int n = int'(b[4:0]);
    logic [63:0] d = {a, a};
    logic [63:0] t;
    logic signed [31:0] s = a;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a >> n;
      5'd5:  return s >>> n;
      5'd6:  return a << n;
      5'd8:  begin t = d >> n; return t[31:0]; end
      5'd9:  begin t = d << n; return t[63:32]; end
      5'd10: return ~b;
      5'd11: return 32'd0 - b;
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] bus_model(
    input logic [6:0] o
  );
    for (int k = 0; k < 7; k++)
      if (o[k]) return m[k];
    return '0;
  endfunction

  function automatic void chk(
    input string nm, input string f,
    input logic [31:0] got, input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s got %h want %h",
               nm, f, got, want);
    end
  endfunction

  // monitor: drains all expectations at each negedge
  always @(negedge clock) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "bus", bus, e.bus);
      chk(e.nm, "rz", rz, e.rz);
      if (e.cb) chk(e.nm, "bus_req", bus, e.vb);
      if (e.cr) chk(e.nm, "rz_req", rz, e.vr);
    end
  end

  // One cycle: drive just after posedge, queue expectations,
  // advance the model across the next posedge.
  task automatic step(
    input logic [6:0]  i_s,
    input logic [6:0]  o_s,
    input string       nm = "rand",
    input bit          cb = 0,
    input logic [31:0] vb = '0,
    input bit          cr = 0,
    input logic [31:0] vr = '0,
    input bit          clr_lo = 0
  );
    exp_t x;
    logic [31:0] b;
    logic [31:0] nx [7];
    logic [31:0] nrz;
    in_s    = i_s;
    out_s   = o_s;
    pc_junk = $urandom;
    ir_junk = $urandom;
    clear   = ~clr_lo;
    if (clr_lo) begin
      foreach (m[k]) m[k] = '0;
      m_rz = '0;
    end
    b = bus_model(o_s);
    x.nm = nm; x.bus = b; x.rz = m_rz;
    x.cb = cb; x.vb = vb; x.cr = cr; x.vr = vr;
    q.push_back(x);
    nx  = m;
    nrz = m_rz;
    if (!clr_lo) begin
      for (int k = 0; k < 7; k++)
        if (i_s[k] && !o_s[k])
          nx[k] = (k < 4 && o_s == 7'd0) ? imm[k] : b;
      if ((o_s[5] | o_s[6]) && !i_s[4])
        nrz = alu_model(m[1][31:27], m[4], b);
    end
    @(posedge clock);
    #1;
    m    = nx;
    m_rz = nrz;
  endtask

  // load register k; IR/R* go over the bus from MDR
  task automatic ld(
    input int k, input logic [31:0] v,
    input bit imm_path = 0
  );
    logic [6:0] bit_k;
    bit_k = 7'd1 << k;
    if (k == 3 || (k < 4 && imm_path)) begin
      imm[k] = v;
      step(bit_k, 7'd0);
    end else begin
      imm[3] = v;
      step(B_MDR, 7'd0);
      step(bit_k, B_MDR);
    end
  endtask

  task automatic alu_t(
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] want,
    input string       nm
  );
    ld(5, a);
    ld(6, b);
    ld(1, {op, 27'd0});
    step(B_RY, B_R0);
    step(7'd0, B_R1, {nm, "_b"}, 1, b);
    step(7'd0, 7'd0, nm, 0, '0, 1, want);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b0;
    in_s   = '0;
    out_s  = '0;
    foreach (imm[k]) imm[k] = '0;
    foreach (m[k]) m[k] = '0;
    m_rz    = '0;
    pc_junk = '0;
    ir_junk = '0;
    @(posedge clock);
    #1;
    step(7'h7f, B_PC, "reset", 1, '0, 1, '0, 1);

    alu_t(5'b01000, 32'h3, 32'h2,
          32'hC0000000, "ror");
    alu_t(5'b00000, 32'd5, 32'd7,
          32'h0000000C, "add");
    alu_t(5'b00000, 32'hFFFFFFFF, 32'd1,
          32'h0, "add_wrap");
    alu_t(5'b01000, 32'h12345678, 32'd0,
          32'h12345678, "ror0");
    alu_t(5'b00101, 32'h80000000, 32'd4,
          32'hF8000000, "shra");
    alu_t(5'b00001, 32'd5, 32'd7,
          32'hFFFFFFFE, "sub");
    alu_t(5'b00010, 32'hF0F0FF00, 32'h0FF0F0F0,
          32'h00F0F000, "and");
    alu_t(5'b00011, 32'hF0F0FF00, 32'h0FF0F0F0,
          32'hFFF0FFF0, "or");
    alu_t(5'b00100, 32'h80000000, 32'd4,
          32'h08000000, "shr");
    alu_t(5'b00110, 32'h3, 32'd4,
          32'h00000030, "shl");
    alu_t(5'b01001, 32'hC0000001, 32'd1,
          32'h80000003, "rol");
    alu_t(5'b01001, 32'h80000001, 32'd36,
          32'h00000018, "rol_b40");
    alu_t(5'b01010, 32'd0, 32'h0000FFFF,
          32'hFFFF0000, "not");
    alu_t(5'b01011, 32'd0, 32'd1,
          32'hFFFFFFFF, "neg");
    alu_t(5'b11111, 32'd9, 32'h1234,
          32'h00001234, "pass");

    // bus priority and idle bus
    ld(0, 32'h10, 1);
    ld(5, 32'h20);
    step(7'd0, B_PC | B_R0, "prio", 1, 32'h10);
    step(7'd0, 7'd0, "idle_bus", 1, 32'h0);

    // MAR: immediate when bus idle, bus otherwise
    imm[2] = 32'hAB;
    step(B_MAR, 7'd0);
    step(7'd0, B_MAR, "mar_imm", 1, 32'hAB);
    ld(6, 32'h55);
    imm[2] = 32'h99;
    step(B_MAR, B_R1);
    step(7'd0, B_MAR, "mar_bus", 1, 32'h55);

    // own in+out keeps value
    step(B_R1, B_R1, "self_rw", 1, 32'h55);
    step(7'd0, B_R1, "self_keep", 1, 32'h55);

    // mid-cycle clear after loading registers
    alu_t(5'b00000, 32'd5, 32'd7,
          32'h0000000C, "add_pre_rst");
    ld(0, 32'h77, 1);
    step(7'd0, B_R0, "rst_mid", 1, '0, 1, '0, 1);
    foreach (imm[k]) imm[k] = 32'hDEADBEEF;
    for (int k = 0; k < 7; k++)
      step(7'h7f, 7'(1 << k), "rst_hold",
           1, '0, 1, '0, 1);
    for (int k = 0; k < 7; k++)
      step(7'd0, 7'(1 << k), "rst_after",
           1, '0, 1, '0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [6:0] ri;
      logic [6:0] ro;
      bit rc;
      ri = 7'($urandom);
      ro = 7'($urandom & $urandom);
      for (int k = 0; k < 4; k++)
        imm[k] = $urandom;
      imm[1][31:27] = 5'($urandom_range(0, 12));
      rc = ($urandom_range(0, 49) == 0);
      step(ri, ro, "rand", 0, '0, 0, '0, rc);
    end

    step(7'd0, 7'd0);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0",
               q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clock and clear.
REQ-002 clock  input  1  rising-edge clock for all registers.
REQ-003 clear  input  1  async active-low reset; 0 clears all registers.
REQ-004 pci, pco, iri, iro, mari, maro, mdri, mdro, ryi, ryo, r0i, r0o, r1i, r1o  input  1 each  register in-strobes (*i: load at posedge) and out-strobes (*o: drive the bus).
REQ-005 pc_immediate, ir_immediate, mar_immediate, mdr_immediate  input  32 each  external load values for PC, IR, MAR and MDR.
REQ-006 pc, ir  input  32 each  reserved inputs; they SHALL have no effect.
REQ-007 bus  output  32  current internal bus value (combinational).
REQ-008 rz  output  32  ALU result register.

Function
REQ-009 Internal 32-bit registers SHALL be PC, IR, MAR, MDR, RY, R0, R1 and RZ.
REQ-010 The bus SHALL be combinational, driven by the highest-priority asserted out-strobe: pco > iro > maro > mdro > ryo > r0o > r1o.
REQ-011 With no out-strobe asserted, the bus SHALL be 0x00000000.
REQ-012 RY, R0 and R1 SHALL load the bus at posedge when their in-strobe is 1; otherwise they hold.
REQ-013 PC, IR, MAR and MDR SHALL, at posedge with their in-strobe at 1, load the bus if any out-strobe is asserted, otherwise load their *_immediate input.
REQ-014 Simultaneous in- and out-strobe on the same register SHALL reload its own value, leaving it unchanged.
REQ-015 Several in-strobes asserted together SHALL all load the same value in the same cycle.
REQ-016 The ALU SHALL be combinational with A = RY, B = bus, and opcode = IR[31:27].
REQ-017 Opcodes: 00000 ADD A+B; 00001 SUB A-B; 00010 AND; 00011 OR; 00100 SHR (logical A>>B[4:0]); 00101 SHRA (arithmetic); 00110 SHL; 01000 ROR (A rotated right by B[4:0]); 01001 ROL; 01010 NOT B; 01011 NEG (0-B); all other opcodes pass B.
REQ-018 Arithmetic SHALL be 32-bit two's complement modulo 2^32, with no carry or overflow output.
REQ-019 A shift or rotate amount of 0 SHALL return A unchanged; amounts use B[4:0] only.
REQ-020 RZ SHALL load the ALU result at posedge when (r0o or r1o) = 1 and ryi = 0; otherwise it holds.
REQ-021 The ALU result SHALL be registered with one-cycle latency: rz shows the result after the posedge that ends the operand cycle.
REQ-022 The bus output SHALL reflect strobe changes within the same cycle, with no clocked delay.

Reset
REQ-023 clear = 0 SHALL immediately (asynchronously) force PC, IR, MAR, MDR, RY, R0, R1 and RZ to 0x00000000, overriding all strobes.
REQ-024 While clear = 0, no register SHALL load; loading SHALL resume at the first posedge after clear returns to 1.
REQ-025 Reset asserted mid-sequence SHALL discard every partial result, and rz SHALL read 0.

Verification
REQ-026 ROR: the bench SHALL cover this sequence: MDR<=0x3 via mdri, then mdro+r0i; MDR<=0x2, then mdro+r1i; MDR<=0x40000000, then mdro+iri; then r0o+ryi; then r1o. Required response: rz = 0xC0000000 at the next posedge.
REQ-027 ADD: the bench SHALL cover R0=5, R1=7, IR[31:27]=00000, then RY<=R0, then r1o. Required response: rz = 0x0000000C; wrap case 0xFFFFFFFF+1 gives 0x00000000.
REQ-028 Bus priority: the bench SHALL cover pco and r0o asserted together with PC=0x10 and R0=0x20. Required response: bus = 0x10; with no strobes, bus = 0.
REQ-029 Immediate vs bus: the bench SHALL cover mari with no out-strobe and mar_immediate=0xAB (MAR becomes 0xAB), and mari with r1o and R1=0x55 (MAR becomes 0x55).
REQ-030 Reset: the bench SHALL cover clear pulsed low mid-cycle after registers are loaded. Required response: all registers and rz read 0 immediately, without waiting for a clock edge.
REQ-031 ROR by 0, and SHRA of 0x80000000 by 4: the bench SHALL cover both. Required responses: A unchanged, and 0xF8000000.
